// File: rtl/lz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lz_pkg
// Brief    : State encoding and width helper shared by the lz_normalizer slice
// Revision : 1.0
// ============================================================================
package lz_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  // Ceil-log2 usable in constant expressions; lz_clog2(1) is 0.
  function automatic int lz_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lz_norm_datapath.sv
`default_nettype none
// ============================================================================
// Module   : lz_norm_datapath
// Brief    : Work register, shift count and zero flag for the normalizer
// Revision : 1.0
// ============================================================================
module lz_norm_datapath
  import lz_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] work,
  output logic [CW-1:0]    count,
  output logic             zero
);

  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_count;
  logic             r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
    end else if (load) begin
      r_work <= load_data;
      // An all-zero word is reported as fully shifted without iterating.
      if (load_data == '0) begin
        r_zero  <= 1'b1;
        r_count <= CW'(WIDTH);
      end else begin
        r_zero  <= 1'b0;
        r_count <= '0;
      end
    end else if (shift) begin
      r_work  <= {r_work[WIDTH-2:0], 1'b0};
      r_count <= r_count + CW'(1);
    end
  end

  assign work  = r_work;
  assign count = r_count;
  assign zero  = r_zero;

endmodule
`default_nettype wire

// File: rtl/lz_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : lz_normalizer
// Brief    : Iterative left-normalizer, one shift per cycle, valid/ready I/O
// Revision : 1.0
// ============================================================================
module lz_normalizer
  import lz_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = lz_clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_shift,
  output logic             out_zero
);

  state_e           r_state;
  state_e           w_next_state;
  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_work;
  logic [CW-1:0]    w_count;
  logic             w_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_zero || w_work[WIDTH-1]) w_next_state = DONE;
        else                           w_shift      = 1'b1;
      end
      DONE: begin
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  lz_norm_datapath #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .shift     (w_shift),
    .load_data (in_data),
    .work      (w_work),
    .count     (w_count),
    .zero      (w_zero)
  );

  // Handshake flags decode the state register only; no input-to-output paths.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = w_work;
  assign out_shift = w_count;
  assign out_zero  = w_zero;

endmodule
`default_nettype wire

// File: tb/tb_lz_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lz_normalizer
// Brief    : Directed self-checking bench for lz_normalizer (WIDTH=8)
// Revision : 1.0
// ============================================================================
module tb_lz_normalizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_shift;
  logic       out_zero;

  int checks   = 0;
  int failures = 0;
  int lat;

  lz_normalizer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic send(input logic [7:0] data);
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [3:0] s,
                           input logic z);
    chk({tag, "_data"},  {24'd0, out_data}, {24'd0, d});
    chk({tag, "_shift"}, {28'd0, out_shift}, {28'd0, s});
    chk({tag, "_zero"},  {31'd0, out_zero}, {31'd0, z});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_out("rst", 8'h00, 4'd0, 1'b0);
    #10 rst_n = 1'b1;
    tick();

    send(8'b0001_0110);
    wait_valid(lat);
    chk("t1_latency", lat, 32'd4);
    check_out("t1", 8'b1011_0000, 4'd3, 1'b0);
    handshake();
    chk("t1_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_hs_ready", {31'd0, in_ready},  32'd1);

    send(8'h80);
    wait_valid(lat);
    chk("t2_latency", lat, 32'd1);
    check_out("t2", 8'h80, 4'd0, 1'b0);
    handshake();

    send(8'h00);
    wait_valid(lat);
    chk("t3_latency", lat, 32'd1);
    check_out("t3", 8'h00, 4'd8, 1'b1);
    handshake();

    // in_valid held high across two words: only one accept per handshake.
    in_data  = 8'h01;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h33;
    chk("t4_busy_ready", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("t4_latency", lat, 32'd8);
    check_out("t4", 8'h80, 4'd7, 1'b0);
    handshake();
    chk("t4_hs_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_hs_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t4_second_acc", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("t4b_latency", lat, 32'd3);
    check_out("t4b", 8'hCC, 4'd2, 1'b0);
    handshake();

    // Backpressure: results hold and a new word is not captured.
    send(8'h20);
    wait_valid(lat);
    chk("t5_latency", lat, 32'd3);
    in_data  = 8'h0F;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_ready", {31'd0, in_ready},  32'd0);
      check_out("t5_hold", 8'h80, 4'd2, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    handshake();
    chk("t5_rel_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rel_ready", {31'd0, in_ready},  32'd1);
    check_out("t5_after", 8'h80, 4'd2, 1'b0);

    // Asynchronous reset in the middle of SHIFT.
    send(8'h04);
    tick();
    tick();
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", {31'd0, in_ready},  32'd1);
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check_out("t6_rst", 8'h00, 4'd0, 1'b0);
    #3 rst_n = 1'b1;
    tick();
    send(8'h40);
    wait_valid(lat);
    chk("t6_latency", lat, 32'd2);
    check_out("t6", 8'h80, 4'd1, 1'b0);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
